// File: rtl/rr_bus_arbiter_8.sv
// Round-robin arbiter sharing one 8-way resource among 8 requesters, break-before-make.
// Latency: req sampled at edge N -> registered grant visible after edge N; >=1 idle cycle between owners.
// Backpressure: requester holds req to keep ownership; optional MAX_HOLD limit forces a revoke.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   req[7:0]  request vector, bit i = requester i wants/keeps the resource
//   gnt[7:0]  registered one-hot grant, zero when no owner
//   gnt_idx   binary index of the owner, zero when no owner
//   gnt_valid high while a grant is active (equals |gnt)
//   timeout   one-cycle pulse in the idle cycle that follows a forced revoke
module rr_bus_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit so
    // the MAX_HOLD=0 (unlimited) build still has a legal vector.
    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam bit HOLD_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] holdCnt;

    // Rotating priority scan: ptr has highest priority, ptr-1 the lowest.
    logic [2:0] winIdx;
    logic       winFound;
    logic [2:0] cand;

    always_comb begin
        winIdx   = '0;
        winFound = 1'b0;
        cand     = '0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!winFound && req[cand]) begin
                winIdx   = cand;
                winFound = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            holdCnt   <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            // timeout is a pulse; only the forced-revoke branch raises it.
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (winFound) begin
                        gnt       <= 8'b1 << winIdx;
                        gnt_idx   <= winIdx;
                        gnt_valid <= 1'b1;
                        holdCnt   <= '0;
                        // Pointer moves only on grant so the new owner is
                        // last in line at the next arbitration.
                        ptr       <= winIdx + 3'd1;
                        state     <= OWNED;
                    end
                end
                OWNED: begin
                    // Release has priority over timeout on the same edge.
                    if (!req[gnt_idx]) begin
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        holdCnt   <= '0;
                        state     <= IDLE;
                    end else if (HOLD_EN && (holdCnt == HOLD_LAST)) begin
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        holdCnt   <= '0;
                        timeout   <= 1'b1;
                        state     <= IDLE;
                    end else if (holdCnt != CNT_MAX) begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter_8.sv
module tb_rr_bus_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;

    logic [7:0] g4, g16, g0;
    logic [2:0] i4, i16, i0;
    logic       v4, v16, v0;
    logic       t4, t16, t0;

    logic [7:0] prev4, prev16, prev0;
    logic [7:0] expG;

    int checks;
    int failures;

    rr_bus_arbiter_8 #(.MAX_HOLD(4)) u4 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(g4), .gnt_idx(i4), .gnt_valid(v4), .timeout(t4)
    );

    rr_bus_arbiter_8 u16 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(g16), .gnt_idx(i16), .gnt_valid(v16), .timeout(t16)
    );

    rr_bus_arbiter_8 #(.MAX_HOLD(0)) u0 (
        .clk(clk), .rst(rst), .req(req),
        .gnt(g0), .gnt_idx(i0), .gnt_valid(v0), .timeout(t0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Structural invariants plus break-before-make against the previous cycle.
    task automatic inv(input string tag, input logic [7:0] g, input logic [2:0] ix,
                       input logic v, inout logic [7:0] prev);
        logic [7:0] ev;
        ev = 8'(v) << ix;
        chk({tag, ".valid_or"}, 8'(v), 8'(|g));
        chk({tag, ".gnt_vs_idx"}, g, ev);
        chk({tag, ".onehot0"}, 8'($onehot0(g)), 8'd1);
        chk({tag, ".bbm"}, 8'((prev == 8'h00) || (g == 8'h00) || (g == prev)), 8'd1);
        prev = g;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        inv("u4", g4, i4, v4, prev4);
        inv("u16", g16, i16, v16, prev16);
        inv("u0", g0, i0, v0, prev0);
    endtask

    // Assert reset asynchronously, check outputs clear without an edge,
    // hold it across one edge, release away from the edge.
    task automatic doReset();
        rst = 1'b1;
        req = 8'h00;
        #2;
        chk("rst.u4.gnt", g4, 8'h00);
        chk("rst.u4.idx", 8'(i4), 8'd0);
        chk("rst.u4.valid", 8'(v4), 8'd0);
        chk("rst.u4.timeout", 8'(t4), 8'd0);
        chk("rst.u16.gnt", g16, 8'h00);
        chk("rst.u16.timeout", 8'(t16), 8'd0);
        chk("rst.u0.gnt", g0, 8'h00);
        chk("rst.u0.timeout", 8'(t0), 8'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        prev4  = 8'h00;
        prev16 = 8'h00;
        prev0  = 8'h00;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 8'h00;
        prev4    = 8'h00;
        prev16   = 8'h00;
        prev0    = 8'h00;
        expG     = 8'h00;

        // ---- single requester 0, held 5 edges, then dropped ----
        doReset();
        req = 8'h01;
        tick();
        chk("t1.u16.gnt_e1", g16, 8'h01);
        chk("t1.u16.idx_e1", 8'(i16), 8'd0);
        chk("t1.u4.gnt_e1", g4, 8'h01);
        for (int e = 2; e <= 5; e++) begin
            tick();
            chk("t1.u16.gnt_hold", g16, 8'h01);
            chk("t1.u16.timeout_hold", 8'(t16), 8'd0);
            if (e < 5) begin
                chk("t1.u4.gnt_hold", g4, 8'h01);
                chk("t1.u4.timeout_hold", 8'(t4), 8'd0);
            end else begin
                chk("t1.u4.gnt_revoke", g4, 8'h00);
                chk("t1.u4.timeout_revoke", 8'(t4), 8'd1);
            end
        end
        req = 8'h00;
        tick();
        chk("t1.u16.gnt_drop", g16, 8'h00);
        chk("t1.u16.valid_drop", 8'(v16), 8'd0);
        chk("t1.u4.timeout_after", 8'(t4), 8'd0);
        chk("t1.u0.gnt_drop", g0, 8'h00);
        // ptr must now be 1: with req 0 and 1 both set, 1 wins.
        req = 8'h03;
        tick();
        chk("t1.u16.ptr1", g16, 8'h02);
        chk("t1.u16.ptr1_idx", 8'(i16), 8'd1);
        chk("t1.u4.ptr1", g4, 8'h02);
        chk("t1.u0.ptr1", g0, 8'h02);
        req = 8'h00;
        tick();
        chk("t1.u16.release", g16, 8'h00);

        // ---- all requesting, MAX_HOLD=4: rotation 0..7,0 ----
        doReset();
        req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            expG = 8'h01 << (k % 8);
            tick();
            chk("t2.grant", g4, expG);
            chk("t2.grant_idx", 8'(i4), 8'(k % 8));
            chk("t2.grant_timeout", 8'(t4), 8'd0);
            repeat (3) tick();
            chk("t2.hold4", g4, expG);
            tick();
            chk("t2.gap_gnt", g4, 8'h00);
            chk("t2.gap_valid", 8'(v4), 8'd0);
            chk("t2.gap_timeout", 8'(t4), 8'd1);
        end

        // ---- wrap: ptr=6 after owner 5, req=0000_0011 ----
        doReset();
        req = 8'h20;
        tick();
        chk("t3.own5", g4, 8'h20);
        chk("t3.own5_idx", 8'(i4), 8'd5);
        req = 8'h03;
        tick();
        chk("t3.release5", g4, 8'h00);
        chk("t3.release5_timeout", 8'(t4), 8'd0);
        tick();
        chk("t3.wrap_gnt0", g4, 8'h01);
        chk("t3.wrap_idx0", 8'(i4), 8'd0);
        repeat (3) tick();
        tick();
        chk("t3.revoke0", g4, 8'h00);
        chk("t3.revoke0_timeout", 8'(t4), 8'd1);
        tick();
        chk("t3.next_gnt1", g4, 8'h02);
        chk("t3.next_idx1", 8'(i4), 8'd1);

        // ---- owner 3 keeps requesting while 7 waits ----
        doReset();
        req = 8'h08;
        tick();
        chk("t4.own3", g4, 8'h08);
        req = 8'h88;
        for (int e = 0; e < 3; e++) begin
            tick();
            chk("t4.own3_ignores7", g4, 8'h08);
        end
        tick();
        chk("t4.revoke3", g4, 8'h00);
        chk("t4.revoke3_timeout", 8'(t4), 8'd1);
        tick();
        chk("t4.gnt7", g4, 8'h80);
        chk("t4.gnt7_idx", 8'(i4), 8'd7);
        repeat (3) tick();
        tick();
        chk("t4.revoke7_timeout", 8'(t4), 8'd1);
        tick();
        chk("t4.regrant3", g4, 8'h08);
        chk("t4.regrant3_idx", 8'(i4), 8'd3);

        // ---- async reset in the middle of owner 5 ----
        doReset();
        req = 8'h20;
        tick();
        chk("t5.own5", g4, 8'h20);
        tick();
        chk("t5.own5_hold", g4, 8'h20);
        rst = 1'b1;
        #2;
        chk("t5.async_gnt", g4, 8'h00);
        chk("t5.async_idx", 8'(i4), 8'd0);
        chk("t5.async_valid", 8'(v4), 8'd0);
        chk("t5.async_u16_gnt", g16, 8'h00);
        req = 8'h24;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        prev4  = 8'h00;
        prev16 = 8'h00;
        prev0  = 8'h00;
        tick();
        chk("t5.ptr0_gnt2", g4, 8'h04);
        chk("t5.ptr0_idx2", 8'(i4), 8'd2);
        chk("t5.u16_gnt2", g16, 8'h04);

        // ---- MAX_HOLD=0: unlimited ownership ----
        doReset();
        req = 8'h10;
        tick();
        chk("t6.u0_gnt", g0, 8'h10);
        chk("t6.u0_idx", 8'(i0), 8'd4);
        for (int e = 0; e < 99; e++) begin
            tick();
            chk("t6.u0_hold", g0, 8'h10);
            chk("t6.u0_no_timeout", 8'(t0), 8'd0);
        end
        req = 8'h00;
        tick();
        chk("t6.u0_release", g0, 8'h00);
        chk("t6.u0_release_timeout", 8'(t0), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
